// File: rtl/sata_phy_pkg.sv
// Shared SATA PHY constants and the K28.5 comma-lane detector
// used by every lane of the multi-port PHY interface.
package sata_phy_pkg;

    localparam int          DW_W     = 32;
    localparam int          K_W      = 4;
    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_K  = 4'b0001;
    localparam logic [7:0]  K28_5    = 8'hBC;

    typedef struct packed {
        logic       hit;
        logic [1:0] lane;
    } comma_t;

    // A comma counts only when exactly one charisk bit is set and that lane carries K28.5
    function automatic comma_t comma_detect(input logic [31:0] dw, input logic [3:0] k);
        comma_t c;
        c.hit  = 1'b0;
        c.lane = 2'd0;
        case (k)
            4'b0001: begin c.hit = (dw[7:0]   == K28_5); c.lane = 2'd0; end
            4'b0010: begin c.hit = (dw[15:8]  == K28_5); c.lane = 2'd1; end
            4'b0100: begin c.hit = (dw[23:16] == K28_5); c.lane = 2'd2; end
            4'b1000: begin c.hit = (dw[31:24] == K28_5); c.lane = 2'd3; end
            default: begin c.hit = 1'b0;                 c.lane = 2'd0; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sata_phy_if_mp_if.sv
// Link-layer / transceiver bundle for N SATA ports; master = link+GT side, slave = PHY interface.
interface sata_phy_if_mp_if #(parameter int N = 2) ();

    logic [N-1:0]      link_up;
    logic [32*N-1:0]   txdata;
    logic [N-1:0]      txdatak;
    logic [N-1:0]      txdatak_pop;
    logic [32*N-1:0]   gtx_txdata;
    logic [4*N-1:0]    gtx_txdatak;
    logic [32*N-1:0]   gtx_rxdata;
    logic [4*N-1:0]    gtx_rxdatak;
    logic [32*N-1:0]   rxdata;
    logic [N-1:0]      rxdatak;
    logic [N-1:0]      rxvalid;
    logic [N-1:0]      align_lock;

    modport master (
        output link_up, txdata, txdatak, gtx_rxdata, gtx_rxdatak,
        input  txdatak_pop, gtx_txdata, gtx_txdatak, rxdata, rxdatak, rxvalid, align_lock
    );

    modport slave (
        input  link_up, txdata, txdatak, gtx_rxdata, gtx_rxdatak,
        output txdatak_pop, gtx_txdata, gtx_txdatak, rxdata, rxdatak, rxvalid, align_lock
    );

endinterface

// File: rtl/sata_phy_if_lane.sv
// One SATA port: TX ALIGN-pair inserter with pop backpressure, RX comma realigner,
// ALIGN stripping and alignment-lock tracking.
module sata_phy_if_lane
    import sata_phy_pkg::*;
#(
    parameter int C_ALIGN_INTERVAL = 256,
    parameter int C_LOCK_CNT       = 4
) (
    input  logic             phyclk,
    input  logic             phyreset,
    input  logic             link_up,
    input  logic [DW_W-1:0]  txdata,
    input  logic             txdatak,
    output logic             txdatak_pop,
    output logic [DW_W-1:0]  gtx_txdata,
    output logic [K_W-1:0]   gtx_txdatak,
    input  logic [DW_W-1:0]  gtx_rxdata,
    input  logic [K_W-1:0]   gtx_rxdatak,
    output logic [DW_W-1:0]  rxdata,
    output logic             rxdatak,
    output logic             rxvalid,
    output logic             align_lock
);

    localparam int         CW       = $clog2(C_ALIGN_INTERVAL);
    localparam logic [3:0] LOCK_MAX = 4'(C_LOCK_CNT);

    logic [CW-1:0]   cnt_r;
    logic            pop_s;
    logic [31:0]     gtx_txdata_r;
    logic [3:0]      gtx_txdatak_r;

    logic [31:0]     prev_r;
    logic [3:0]      prevk_r;
    logic [1:0]      offset_r, offset_nx_s;
    logic [3:0]      lock_cnt_r, lock_cnt_nx_s;
    logic            align_lock_r, align_lock_nx_s;
    comma_t          det_s;
    logic [55:0]     pair_s;
    logic [31:0]     realign_s;
    logic            realk_s;
    logic [31:0]     rxdata_r;
    logic            rxdatak_r;
    logic            rxvalid_r;

    // Data slots are every period position except the two ALIGN slots at 0 and 1
    always_comb begin
        pop_s = link_up && (cnt_r >= CW'(2));
    end

    // TX period counter and registered transceiver word
    always_ff @(posedge phyclk) begin
        if (phyreset || !link_up) begin
            cnt_r         <= '0;
            gtx_txdata_r  <= ALIGN_DW;
            gtx_txdatak_r <= ALIGN_K;
        end else begin
            cnt_r <= cnt_r + CW'(1);
            if (pop_s) begin
                gtx_txdata_r  <= txdata;
                gtx_txdatak_r <= {3'b000, txdatak};
            end else begin
                gtx_txdata_r  <= ALIGN_DW;
                gtx_txdatak_r <= ALIGN_K;
            end
        end
    end

    // Comma detection on the incoming word and realignment of the previous word
    always_comb begin
        det_s  = comma_detect(gtx_rxdata, gtx_rxdatak);
        pair_s = {gtx_rxdata[23:0], prev_r};
        case (offset_r)
            2'd0:    realign_s = pair_s[31:0];
            2'd1:    realign_s = pair_s[39:8];
            2'd2:    realign_s = pair_s[47:16];
            2'd3:    realign_s = pair_s[55:24];
            default: realign_s = pair_s[31:0];
        endcase
        realk_s = prevk_r[offset_r];
    end

    // Lock bookkeeping: same-offset commas count up, a new offset restarts the count
    always_comb begin
        offset_nx_s     = offset_r;
        lock_cnt_nx_s   = lock_cnt_r;
        align_lock_nx_s = align_lock_r;
        if (!link_up) begin
            lock_cnt_nx_s   = 4'd0;
            align_lock_nx_s = 1'b0;
        end else if (det_s.hit) begin
            if (det_s.lane == offset_r) begin
                if (lock_cnt_r < LOCK_MAX) begin
                    lock_cnt_nx_s = lock_cnt_r + 4'd1;
                end else begin
                    lock_cnt_nx_s = lock_cnt_r;
                end
                align_lock_nx_s = (lock_cnt_nx_s == LOCK_MAX);
            end else begin
                offset_nx_s     = det_s.lane;
                lock_cnt_nx_s   = 4'd1;
                align_lock_nx_s = 1'b0;
            end
        end else begin
            offset_nx_s = offset_r;
        end
    end

    // RX pipeline: previous word, lock state, realigned output stage
    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            prev_r       <= 32'd0;
            prevk_r      <= 4'd0;
            offset_r     <= 2'd0;
            lock_cnt_r   <= 4'd0;
            align_lock_r <= 1'b0;
            rxdata_r     <= 32'd0;
            rxdatak_r    <= 1'b0;
            rxvalid_r    <= 1'b0;
        end else begin
            prev_r       <= gtx_rxdata;
            prevk_r      <= gtx_rxdatak;
            offset_r     <= offset_nx_s;
            lock_cnt_r   <= lock_cnt_nx_s;
            align_lock_r <= align_lock_nx_s;
            rxdata_r     <= realign_s;
            rxdatak_r    <= realk_s;
            rxvalid_r    <= link_up && align_lock_r && (realign_s != ALIGN_DW);
        end
    end

    assign txdatak_pop = pop_s;
    assign gtx_txdata  = gtx_txdata_r;
    assign gtx_txdatak = gtx_txdatak_r;
    assign rxdata      = rxdata_r;
    assign rxdatak     = rxdatak_r;
    assign rxvalid     = rxvalid_r;
    assign align_lock  = align_lock_r;

endmodule

// File: rtl/sata_phy_if_mp.sv
// N-port SATA PHY interface: one independent lane instance per SATA channel,
// the top only slices the shared buses.
module sata_phy_if_mp
    import sata_phy_pkg::*;
#(
    parameter int C_NUM_PORTS      = 2,
    parameter int C_ALIGN_INTERVAL = 256,
    parameter int C_LOCK_CNT       = 4
) (
    input  logic              phyclk,
    input  logic              phyreset,
    sata_phy_if_mp_if.slave   bus
);

    for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
        sata_phy_if_lane #(
            .C_ALIGN_INTERVAL (C_ALIGN_INTERVAL),
            .C_LOCK_CNT       (C_LOCK_CNT)
        ) u_lane (
            .phyclk      (phyclk),
            .phyreset    (phyreset),
            .link_up     (bus.link_up[p]),
            .txdata      (bus.txdata[DW_W*p +: DW_W]),
            .txdatak     (bus.txdatak[p]),
            .txdatak_pop (bus.txdatak_pop[p]),
            .gtx_txdata  (bus.gtx_txdata[DW_W*p +: DW_W]),
            .gtx_txdatak (bus.gtx_txdatak[K_W*p +: K_W]),
            .gtx_rxdata  (bus.gtx_rxdata[DW_W*p +: DW_W]),
            .gtx_rxdatak (bus.gtx_rxdatak[K_W*p +: K_W]),
            .rxdata      (bus.rxdata[DW_W*p +: DW_W]),
            .rxdatak     (bus.rxdatak[p]),
            .rxvalid     (bus.rxvalid[p]),
            .align_lock  (bus.align_lock[p])
        );
    end

endmodule

// File: tb/tb_sata_phy_if_mp.sv
// Directed bench for the 2-port SATA PHY interface: TX ALIGN insertion, RX realignment,
// lock/unlock, ALIGN stripping and mid-traffic reset.
module tb_sata_phy_if_mp;

    localparam logic [31:0] EXP_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SOF       = 32'h3737B57C;
    localparam int          PERIOD    = 256;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   pops_seen;
    int   pops_period;
    logic [31:0] rx_lp;
    logic [3:0]  rx_lk;

    sata_phy_if_mp_if #(.N(2)) bus ();

    sata_phy_if_mp #(
        .C_NUM_PORTS      (2),
        .C_ALIGN_INTERVAL (PERIOD),
        .C_LOCK_CNT       (4)
    ) dut (
        .phyclk   (clk),
        .phyreset (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one TX dword on port p at period position c and check pop and the registered output
    task automatic tx_step(input int p, input int c);
        logic [31:0] d;
        logic        k;
        logic        exp_pop;
        d       = 32'hA000_0000 + 32'(p) * 32'h0100_0000 + 32'(c);
        k       = ((c % 50) == 7);
        exp_pop = ((c % PERIOD) >= 2);
        bus.txdata[32*p +: 32] = d;
        bus.txdatak[p]         = k;
        #1;
        chk("tx_pop", 64'(bus.txdatak_pop[p]), 64'(exp_pop));
        if (bus.txdatak_pop[p]) pops_seen++;
        tick();
        chk("tx_data", 64'(bus.gtx_txdata[32*p +: 32]), 64'(exp_pop ? d : EXP_ALIGN));
        chk("tx_k", 64'(bus.gtx_txdatak[4*p +: 4]), 64'(exp_pop ? {3'b000, k} : 4'b0001));
    endtask

    // Send one logical RX dword on port 0 with the byte stream rotated by r lanes
    task automatic rx_send(input logic [31:0] l, input logic [3:0] lk, input int r);
        logic [63:0] pair;
        logic [7:0]  kp;
        pair = {l, rx_lp};
        kp   = {lk, rx_lk};
        pair = pair >> (32 - 8 * r);
        kp   = kp >> (4 - r);
        bus.gtx_rxdata[31:0] = pair[31:0];
        bus.gtx_rxdatak[3:0] = kp[3:0];
        rx_lp = l;
        rx_lk = lk;
        tick();
    endtask

    task automatic rx_raw(input logic [31:0] w, input logic [3:0] k);
        bus.gtx_rxdata[31:0] = w;
        bus.gtx_rxdatak[3:0] = k;
        tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_gtx_txdata"}, 64'(bus.gtx_txdata), 64'({EXP_ALIGN, EXP_ALIGN}));
        chk({tag, "_gtx_txdatak"}, 64'(bus.gtx_txdatak), 64'(8'h11));
        chk({tag, "_pop"}, 64'(bus.txdatak_pop), 64'(2'b00));
        chk({tag, "_rxdata"}, 64'(bus.rxdata), 64'd0);
        chk({tag, "_rxdatak"}, 64'(bus.rxdatak), 64'(2'b00));
        chk({tag, "_rxvalid"}, 64'(bus.rxvalid), 64'(2'b00));
        chk({tag, "_lock"}, 64'(bus.align_lock), 64'(2'b00));
    endtask

    initial begin
        errors = 0; checks = 0; pops_seen = 0; pops_period = 0;
        rx_lp = 32'd0; rx_lk = 4'd0;
        rst = 1'b1;
        bus.link_up     = 2'b00;
        bus.txdata      = 64'd0;
        bus.txdatak     = 2'b00;
        bus.gtx_rxdata  = 64'd0;
        bus.gtx_rxdatak = 8'd0;
        tick();
        tick();
        chk_reset_state("reset");

        // Link down: continuous ALIGN, no pops
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("down_gtx_txdata", 64'(bus.gtx_txdata[31:0]), 64'(EXP_ALIGN));
            chk("down_gtx_txdatak", 64'(bus.gtx_txdatak[3:0]), 64'(4'b0001));
            chk("down_pop", 64'(bus.txdatak_pop[0]), 64'd0);
        end

        // Full ALIGN period plus wrap on port 0; port 1 stays down
        bus.link_up[0] = 1'b1;
        for (int c = 0; c < 260; c++) begin
            tx_step(0, c);
            if (c == PERIOD - 1) pops_period = pops_seen;
            if ((c % 64) == 0) begin
                chk("p1_idle_txdata", 64'(bus.gtx_txdata[63:32]), 64'(EXP_ALIGN));
                chk("p1_idle_pop", 64'(bus.txdatak_pop[1]), 64'd0);
            end
        end
        chk("pops_per_period", 64'(pops_period), 64'd254);

        // Link drop mid-period, then restart with two ALIGNs
        bus.link_up[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drop_pop", 64'(bus.txdatak_pop[0]), 64'd0);
            tick();
            chk("drop_gtx_txdata", 64'(bus.gtx_txdata[31:0]), 64'(EXP_ALIGN));
        end
        bus.link_up[0] = 1'b1;
        for (int c = 0; c < 6; c++) tx_step(0, c);

        // RX rotated by 2 lanes: lock on the 4th ALIGN, SOF realigned
        rx_send(32'h11223344, 4'b0000, 2);
        for (int i = 0; i < 4; i++) begin
            rx_send(EXP_ALIGN, 4'b0001, 2);
            if (i == 2) chk("lock_after_3", 64'(bus.align_lock[0]), 64'd0);
        end
        chk("lock_after_4", 64'(bus.align_lock[0]), 64'd1);
        chk("p1_lock_idle", 64'(bus.align_lock[1]), 64'd0);
        rx_send(SOF, 4'b0001, 2);
        chk("align_stripped_data", 64'(bus.rxdata[31:0]), 64'(EXP_ALIGN));
        chk("align_stripped_valid", 64'(bus.rxvalid[0]), 64'd0);
        rx_send(32'hCAFEF00D, 4'b0000, 2);
        chk("sof_data", 64'(bus.rxdata[31:0]), 64'(SOF));
        chk("sof_k", 64'(bus.rxdatak[0]), 64'd1);
        chk("sof_valid", 64'(bus.rxvalid[0]), 64'd1);
        rx_send(EXP_ALIGN, 4'b0001, 2);
        chk("d1_data", 64'(bus.rxdata[31:0]), 64'(32'hCAFEF00D));
        chk("d1_k", 64'(bus.rxdatak[0]), 64'd0);
        chk("d1_valid", 64'(bus.rxvalid[0]), 64'd1);
        rx_send(EXP_ALIGN, 4'b0001, 2);
        chk("a_valid", 64'(bus.rxvalid[0]), 64'd0);
        rx_send(32'h01020304, 4'b0000, 2);
        chk("a2_valid", 64'(bus.rxvalid[0]), 64'd0);
        rx_send(32'h05060708, 4'b0000, 2);
        chk("d2_data", 64'(bus.rxdata[31:0]), 64'(32'h01020304));
        chk("d2_valid", 64'(bus.rxvalid[0]), 64'd1);

        // Non-comma lane K28.5 and multi-bit charisk leave lock untouched
        rx_raw(32'h0000BC00, 4'b0001);
        rx_raw(32'h0000BCBC, 4'b0011);
        chk("no_detect_lock", 64'(bus.align_lock[0]), 64'd1);

        // Relock at offset 0, then single lane-1 ALIGN breaks lock
        for (int i = 0; i < 4; i++) begin
            rx_send(EXP_ALIGN, 4'b0001, 0);
            if (i == 0) chk("move0_unlock", 64'(bus.align_lock[0]), 64'd0);
        end
        chk("lock_off0", 64'(bus.align_lock[0]), 64'd1);
        rx_send(SOF, 4'b0001, 0);
        rx_send(32'h99887766, 4'b0000, 0);
        chk("off0_sof_data", 64'(bus.rxdata[31:0]), 64'(SOF));
        chk("off0_sof_valid", 64'(bus.rxvalid[0]), 64'd1);
        rx_send(EXP_ALIGN, 4'b0001, 1);
        chk("lane1_unlock", 64'(bus.align_lock[0]), 64'd0);
        for (int i = 0; i < 4; i++) rx_send(EXP_ALIGN, 4'b0001, 1);
        chk("lock_off1", 64'(bus.align_lock[0]), 64'd1);
        rx_send(SOF, 4'b0001, 1);
        rx_send(32'h55AA33CC, 4'b0000, 1);
        chk("off1_sof_data", 64'(bus.rxdata[31:0]), 64'(SOF));
        chk("off1_sof_k", 64'(bus.rxdatak[0]), 64'd1);
        chk("off1_sof_valid", 64'(bus.rxvalid[0]), 64'd1);

        // Port 1 traffic, then mid-traffic reset returns both ports to reset state
        bus.link_up[1] = 1'b1;
        for (int c = 0; c < 6; c++) tx_step(1, c);
        rst = 1'b1;
        bus.txdata[63:32] = 32'hDEADBEEF;
        tick();
        chk_reset_state("midreset");
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tx_step(1, c);
        chk("post_reset_lock", 64'(bus.align_lock[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
